mips_exec_unit: RTL and testbench

Execute-stage arithmetic block of the multi-cycle MIPS CPU. It bundles:
- the ALU control decoder (ALUOp plus function code to a 4-bit ALU operation);
- the 32-bit main ALU with zero flag;
- the branch-target adder (PC plus shifted offset);
- a registered ALUOut/zero holding stage.

It sits between the register file / immediate mux and the PC-select and memory-address muxes.

---
 rtl/mips_exec_unit.sv | 71 +++++++
 tb/tb_mips_exec_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/mips_exec_unit.sv
// mips_exec_unit: execute stage with ALU control decode, 32-bit ALU, branch-target adder and ALUOut/zero holding registers
module mips_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  func_code,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc_in,
  input  logic [31:0] offset,
  input  logic        alu_load,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] add_out,
  output logic [31:0] alu_out_q,
  output logic        zero_q
);
  logic [3:0]  funct_ctrl;
  logic [31:0] alu_out_d;
  logic        zero_d;
  always_comb begin
    case (func_code)
      6'b100000, 6'b100001: funct_ctrl = 4'b0010;
      6'b100010, 6'b100011: funct_ctrl = 4'b0110;
      6'b100100:            funct_ctrl = 4'b0000;
      6'b100101:            funct_ctrl = 4'b0001;
      6'b100110:            funct_ctrl = 4'b0011;
      6'b100111:            funct_ctrl = 4'b1100;
      6'b101010:            funct_ctrl = 4'b0111;
      6'b101011:            funct_ctrl = 4'b1000;
      6'b000000:            funct_ctrl = 4'b1001;
      6'b000010:            funct_ctrl = 4'b1010;
      6'b000011:            funct_ctrl = 4'b1011;
      default:              funct_ctrl = 4'b1111;
    endcase
    alu_ctrl = alu_op == 2'b00 ? 4'b0010 :
               alu_op == 2'b01 ? 4'b0110 :
               alu_op == 2'b11 ? 4'b0001 : funct_ctrl;
  end
  always_comb begin
    case (alu_ctrl)
      4'b0010: result = a + b;
      4'b0110: result = a - b;
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0011: result = a ^ b;
      4'b1100: result = ~(a | b);
      4'b0111: result = {31'd0, $signed(a) < $signed(b)};
      4'b1000: result = {31'd0, a < b};
      4'b1001: result = b << shamt;
      4'b1010: result = b >> shamt;
      4'b1011: result = $unsigned($signed(b) >>> shamt);
      default: result = 32'd0;
    endcase
    zero = result == 32'd0;
    add_out = pc_in + offset;
    alu_out_d = alu_load ? result : alu_out_q;
    zero_d = alu_load ? zero : zero_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_out_q <= 32'd0;
      zero_q <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_mips_exec_unit.sv
// tb_mips_exec_unit: directed self-checking bench for mips_exec_unit
module tb_mips_exec_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  func_code;
  logic [4:0]  shamt;
  logic [31:0] a, b, pc_in, offset;
  logic        alu_load;
  logic [3:0]  alu_ctrl;
  logic [31:0] result, add_out, alu_out_q;
  logic        zero, zero_q;
  int passed = 0;
  int total = 0;
  mips_exec_unit dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .func_code(func_code), .shamt(shamt),
    .a(a), .b(b), .pc_in(pc_in), .offset(offset), .alu_load(alu_load),
    .alu_ctrl(alu_ctrl), .result(result), .zero(zero), .add_out(add_out),
    .alu_out_q(alu_out_q), .zero_q(zero_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [1:0] o, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    alu_op = o; func_code = f; a = x; b = y;
    #1;
  endtask
  initial begin
    reset = 1'b0; alu_load = 1'b1; alu_op = 2'b00; func_code = 6'd0; shamt = 5'd0;
    a = 32'h5; b = 32'h6; pc_in = 32'd0; offset = 32'd0;
    edge_tick();
    chk("rst_out", alu_out_q, 32'd0);
    chk("rst_zero", {31'd0, zero_q}, 32'd0);
    reset = 1'b1; alu_load = 1'b0;
    op(2'b00, 6'b111111, 32'hFFFFFFFF, 32'd1);
    chk("add_ctrl", {28'd0, alu_ctrl}, 32'h2);
    chk("add_wrap", result, 32'd0);
    chk("add_zero", {31'd0, zero}, 32'd1);
    alu_load = 1'b1;
    edge_tick();
    alu_load = 1'b0;
    chk("load_out", alu_out_q, 32'd0);
    chk("load_zero", {31'd0, zero_q}, 32'd1);
    op(2'b10, 6'b101010, 32'hFFFFFFFE, 32'd1);
    chk("slt", result, 32'd1);
    chk("slt_ctrl", {28'd0, alu_ctrl}, 32'h7);
    op(2'b10, 6'b101011, 32'hFFFFFFFE, 32'd1);
    chk("sltu", result, 32'd0);
    shamt = 5'd4;
    op(2'b10, 6'b000011, 32'd0, 32'h80000000);
    chk("sra", result, 32'hF8000000);
    op(2'b10, 6'b000010, 32'd0, 32'h80000000);
    chk("srl", result, 32'h08000000);
    op(2'b10, 6'b000000, 32'd0, 32'h80000001);
    chk("sll", result, 32'h00000010);
    op(2'b01, 6'b000000, 32'h1234, 32'h1234);
    chk("sub_eq", result, 32'd0);
    chk("sub_zero", {31'd0, zero}, 32'd1);
    op(2'b10, 6'b100011, 32'h5, 32'h7);
    chk("subu", result, 32'hFFFFFFFE);
    pc_in = 32'hBFC00000; offset = 32'h10; #1;
    chk("br_add", add_out, 32'hBFC00010);
    pc_in = 32'hFFFFFFFC; offset = 32'h8; #1;
    chk("br_wrap", add_out, 32'h4);
    op(2'b10, 6'b111111, 32'h1234, 32'h5678);
    chk("inv_ctrl", {28'd0, alu_ctrl}, 32'hF);
    chk("inv_res", result, 32'd0);
    chk("inv_zero", {31'd0, zero}, 32'd1);
    op(2'b11, 6'b100000, 32'hF0, 32'h0F);
    chk("ori", result, 32'hFF);
    op(2'b10, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0);
    chk("and", result, 32'h0F000F00);
    op(2'b10, 6'b100101, 32'hFF00FF00, 32'h0FF00FF0);
    chk("or", result, 32'hFFF0FFF0);
    op(2'b10, 6'b100110, 32'hFF00FF00, 32'h0FF00FF0);
    chk("xor", result, 32'hF0F0F0F0);
    op(2'b10, 6'b100111, 32'hFF00FF00, 32'h0FF00FF0);
    chk("nor", result, 32'h000F000F);
    chk("nor_zero", {31'd0, zero}, 32'd0);
    op(2'b10, 6'b100001, 32'hDEAD0000, 32'h0000BEEF);
    alu_load = 1'b1;
    edge_tick();
    alu_load = 1'b0;
    chk("cap_out", alu_out_q, 32'hDEADBEEF);
    chk("cap_zero", {31'd0, zero_q}, 32'd0);
    op(2'b00, 6'd0, 32'd1, 32'd1);
    edge_tick();
    chk("hold_out", alu_out_q, 32'hDEADBEEF);
    reset = 1'b0; alu_load = 1'b1;
    op(2'b00, 6'd0, 32'hFFFFFFFF, 32'd1);
    chk("rst_comb", {31'd0, zero}, 32'd1);
    edge_tick();
    chk("rst2_out", alu_out_q, 32'd0);
    chk("rst2_zero", {31'd0, zero_q}, 32'd0);
    reset = 1'b1; alu_load = 1'b0;
    edge_tick();
    edge_tick();
    chk("post_out", alu_out_q, 32'd0);
    chk("post_zero", {31'd0, zero_q}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
